// File: rtl/pipe2_reg_pkg.sv
// Shared widths and memory-op encodings for the decode/execute pipeline register.
package pipe2_reg_pkg;

   localparam int DATA_W  = 128;
   localparam int ADDR_W  = 21;
   localparam int BEN_W   = DATA_W / 8;
   localparam int RADDR_W = 5;
   localparam int ALUOP_W = 5;

   // memop is big-endian: bit 0 (MSB) requests an access, bit 1 makes it a write
   typedef enum logic [0:1] {
      MEMOP_NONE  = 2'b00,
      MEMOP_RSVD  = 2'b01,
      MEMOP_LOAD  = 2'b10,
      MEMOP_STORE = 2'b11
   } memop_e;

endpackage

// File: rtl/pipe2_reg_if.sv
// Signal bundle between decode/register-read (master) and the pipe2 register (slave).
import pipe2_reg_pkg::*;

interface pipe2_reg_if;

   logic [0:ALUOP_W-1] aluop_in;
   logic [0:ALUOP_W-1] aluop_out;
   logic [0:2]         ppp_in;
   logic [0:2]         ppp_out;
   logic [0:1]         ww_in;
   logic [0:1]         ww_out;
   logic [0:1]         memop_in;
   logic               memWrEn_out;
   logic               memEn_out;
   logic [0:ADDR_W-1]  memAddr_in;
   logic [0:ADDR_W-1]  memAddr_out;
   logic [0:BEN_W-1]   wbyteen_in;
   logic [0:BEN_W-1]   wbyteen_out;
   logic               regwren_in;
   logic               regwren_out;
   logic [0:RADDR_W-1] rwraddrd_in;
   logic [0:RADDR_W-1] rwraddrd_out;
   logic               reginmuxop_in;
   logic               reginmuxop_out;
   logic [0:DATA_W-1]  rd1data_in;
   logic [0:DATA_W-1]  rd1data_out;
   logic [0:DATA_W-1]  rd2data_in;
   logic [0:DATA_W-1]  rd2data_out;

   modport master (
      output aluop_in, ppp_in, ww_in, memop_in, memAddr_in, wbyteen_in,
             regwren_in, rwraddrd_in, reginmuxop_in, rd1data_in, rd2data_in,
      input  aluop_out, ppp_out, ww_out, memWrEn_out, memEn_out, memAddr_out,
             wbyteen_out, regwren_out, rwraddrd_out, reginmuxop_out,
             rd1data_out, rd2data_out
   );

   modport slave (
      input  aluop_in, ppp_in, ww_in, memop_in, memAddr_in, wbyteen_in,
             regwren_in, rwraddrd_in, reginmuxop_in, rd1data_in, rd2data_in,
      output aluop_out, ppp_out, ww_out, memWrEn_out, memEn_out, memAddr_out,
             wbyteen_out, regwren_out, rwraddrd_out, reginmuxop_out,
             rd1data_out, rd2data_out
   );

endinterface

// File: rtl/pipe2_reg_memop_decode.sv
// Splits the 2-bit memop into access and write strobes; the reserved code is a no-op.
import pipe2_reg_pkg::*;

module memop_decode (
   input  logic [0:1] memop,
   output logic       mem_en,
   output logic       mem_wr_en
);

   always_comb begin
      mem_en    = 1'b0;
      mem_wr_en = 1'b0;
      case (memop)
         MEMOP_LOAD: begin
            mem_en = 1'b1;
         end
         MEMOP_STORE: begin
            mem_en    = 1'b1;
            mem_wr_en = 1'b1;
         end
         default: begin
            mem_en    = 1'b0;
            mem_wr_en = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pipe2_reg.sv
// Pipeline register between decode/register-read and execute; one-cycle latency, sync reset clears all.
import pipe2_reg_pkg::*;

module pipe2_reg (
   input  logic          clk,
   input  logic          reset,
   pipe2_reg_if.slave    bus
);

   logic mem_en_next;
   logic mem_wr_en_next;

   memop_decode u_memop_decode (
      .memop     (bus.memop_in),
      .mem_en    (mem_en_next),
      .mem_wr_en (mem_wr_en_next)
   );

   // Reset wins over capture, so a word in flight during reset is dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.aluop_out      <= '0;
         bus.ppp_out        <= '0;
         bus.ww_out         <= '0;
         bus.memEn_out      <= 1'b0;
         bus.memWrEn_out    <= 1'b0;
         bus.memAddr_out    <= '0;
         bus.wbyteen_out    <= '0;
         bus.regwren_out    <= 1'b0;
         bus.rwraddrd_out   <= '0;
         bus.reginmuxop_out <= 1'b0;
         bus.rd1data_out    <= '0;
         bus.rd2data_out    <= '0;
      end else begin
         bus.aluop_out      <= bus.aluop_in;
         bus.ppp_out        <= bus.ppp_in;
         bus.ww_out         <= bus.ww_in;
         bus.memEn_out      <= mem_en_next;
         bus.memWrEn_out    <= mem_wr_en_next;
         bus.memAddr_out    <= bus.memAddr_in;
         bus.wbyteen_out    <= bus.wbyteen_in;
         bus.regwren_out    <= bus.regwren_in;
         bus.rwraddrd_out   <= bus.rwraddrd_in;
         bus.reginmuxop_out <= bus.reginmuxop_in;
         bus.rd1data_out    <= bus.rd1data_in;
         bus.rd2data_out    <= bus.rd2data_in;
      end
   end

endmodule

// File: tb/tb_pipe2_reg.sv
// Scoreboard bench for pipe2_reg: driver queues model predictions, monitor checks each edge.
import pipe2_reg_pkg::*;

module tb_pipe2_reg;

   typedef struct packed {
      logic               reset;
      logic [0:ALUOP_W-1] aluop;
      logic [0:2]         ppp;
      logic [0:1]         ww;
      logic [0:1]         memop;
      logic [0:ADDR_W-1]  addr;
      logic [0:BEN_W-1]   wbyteen;
      logic               regwren;
      logic [0:RADDR_W-1] rwraddrd;
      logic               reginmuxop;
      logic [0:DATA_W-1]  rd1;
      logic [0:DATA_W-1]  rd2;
   } stim_t;

   typedef struct packed {
      logic [0:ALUOP_W-1] aluop;
      logic [0:2]         ppp;
      logic [0:1]         ww;
      logic               mem_en;
      logic               mem_wr_en;
      logic [0:ADDR_W-1]  addr;
      logic [0:BEN_W-1]   wbyteen;
      logic               regwren;
      logic [0:RADDR_W-1] rwraddrd;
      logic               reginmuxop;
      logic [0:DATA_W-1]  rd1;
      logic [0:DATA_W-1]  rd2;
   } out_t;

   logic clk = 1'b0;
   logic reset;
   int   num_checks = 0;
   int   num_fail   = 0;

   out_t  exp_q[$];
   string tag_q[$];

   pipe2_reg_if bus ();

   pipe2_reg dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: reset clears everything, otherwise fields pass and memop follows the op table
   function automatic out_t model(input stim_t s);
      out_t o;
      o = '0;
      if (!s.reset) begin
         o.aluop      = s.aluop;
         o.ppp        = s.ppp;
         o.ww         = s.ww;
         o.mem_en     = (s.memop == 2'b10) || (s.memop == 2'b11);
         o.mem_wr_en  = (s.memop == 2'b11);
         o.addr       = s.addr;
         o.wbyteen    = s.wbyteen;
         o.regwren    = s.regwren;
         o.rwraddrd   = s.rwraddrd;
         o.reginmuxop = s.reginmuxop;
         o.rd1        = s.rd1;
         o.rd2        = s.rd2;
      end
      return o;
   endfunction

   function automatic logic [0:DATA_W-1] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic stim_t randStim();
      stim_t s;
      s.reset      = 1'b0;
      s.aluop      = ALUOP_W'($urandom);
      s.ppp        = 3'($urandom);
      s.ww         = 2'($urandom);
      s.memop      = 2'($urandom);
      s.addr       = ADDR_W'($urandom);
      s.wbyteen    = BEN_W'($urandom);
      s.regwren    = 1'($urandom);
      s.rwraddrd   = RADDR_W'($urandom);
      s.reginmuxop = 1'($urandom);
      s.rd1        = rand128();
      s.rd2        = rand128();
      return s;
   endfunction

   task automatic driveInputs(input stim_t s);
      bus.aluop_in      = s.aluop;
      bus.ppp_in        = s.ppp;
      bus.ww_in         = s.ww;
      bus.memop_in      = s.memop;
      bus.memAddr_in    = s.addr;
      bus.wbyteen_in    = s.wbyteen;
      bus.regwren_in    = s.regwren;
      bus.rwraddrd_in   = s.rwraddrd;
      bus.reginmuxop_in = s.reginmuxop;
      bus.rd1data_in    = s.rd1;
      bus.rd2data_in    = s.rd2;
   endtask

   // One cycle: drive, predict, let the edge capture, then scramble inputs mid-cycle
   task automatic applyStimulus(input string tag, input stim_t s);
      reset = s.reset;
      driveInputs(s);
      exp_q.push_back(model(s));
      tag_q.push_back(tag);
      @(posedge clk);
      #2;
      driveInputs(randStim());
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input out_t expv);
      out_t act;
      act.aluop      = bus.aluop_out;
      act.ppp        = bus.ppp_out;
      act.ww         = bus.ww_out;
      act.mem_en     = bus.memEn_out;
      act.mem_wr_en  = bus.memWrEn_out;
      act.addr       = bus.memAddr_out;
      act.wbyteen    = bus.wbyteen_out;
      act.regwren    = bus.regwren_out;
      act.rwraddrd   = bus.rwraddrd_out;
      act.reginmuxop = bus.reginmuxop_out;
      act.rd1        = bus.rd1data_out;
      act.rd2        = bus.rd2data_out;
      num_checks++;
      if (act !== expv) begin
         num_fail++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: every edge presents a word; check just after the edge and again after the input scramble
   initial begin
      out_t  cur;
      string tag;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            tag = tag_q.pop_front();
            checkOutput({tag, "_edge"}, cur);
            #3;
            checkOutput({tag, "_hold"}, cur);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      stim_t s;
      logic [0:DATA_W-1] pat;
      logic [0:1] mop;

      for (int i = 0; i < 2; i++) begin
         s = randStim();
         s.reset = 1'b1;
         applyStimulus("reset", s);
      end

      s = '0;
      s.aluop = 5'd1; s.ppp = 3'd1; s.ww = 2'd1; s.memop = 2'b11;
      s.addr = 21'd1; s.wbyteen = 16'd1; s.regwren = 1'b1; s.rwraddrd = 5'd1;
      s.reginmuxop = 1'b1; s.rd1 = 128'h1; s.rd2 = 128'h1;
      applyStimulus("ones", s);

      for (int i = 0; i < 4; i++) begin
         mop = 2'(i);
         s = randStim();
         s.memop = mop;
         applyStimulus("memop_sweep", s);
      end

      for (int i = 0; i < 3; i++) begin
         pat = (i == 0) ? {DATA_W{1'b1}} : (i == 1) ? {(DATA_W/2){2'b01}} : '0;
         s = randStim();
         s.rd1 = pat;
         applyStimulus("back_to_back", s);
      end

      for (int i = 0; i < 5; i++) begin
         s = randStim();
         s.reset = (i == 2);
         applyStimulus("mid_reset", s);
      end

      for (int i = 0; i < 300; i++) begin
         s = randStim();
         s.reset = ($urandom_range(0, 15) == 0);
         applyStimulus("random", s);
      end

      @(posedge clk);
      #6;
      num_checks++;
      if (exp_q.size() != 0) begin
         num_fail++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule
